// File: rtl/amiq_fifo_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// amiq_fifo_cfg_ctrl
//   Configuration sequencer for a FIFO control interface. It owns the FIFO
//   hard-reset line and the almost-full / almost-empty thresholds.
//   SET_FULL / SET_EMPTY writes land in shadow registers. COMMIT range-checks
//   both shadows and copies them to the active outputs in one step, or pulses
//   o_cfg_err for one cycle. FLUSH issues a timed FIFO reset pulse followed by
//   a recovery window. Power-up behaves exactly like a FLUSH.
//
// Ports
//   i_clk               clock, rising edge
//   i_rst_n             asynchronous active-low reset
//   i_cfg_valid         config request valid
//   o_cfg_ready         request accepted when i_cfg_valid & o_cfg_ready
//   i_cfg_op [1:0]      00 SET_FULL, 01 SET_EMPTY, 10 FLUSH, 11 COMMIT
//   i_cfg_data [P-1:0]  threshold value for SET_* ops
//   o_cfg_err           one-cycle pulse after a rejected COMMIT
//   o_busy              high while flushing or recovering
//   o_fifo_rst_n        hard reset to the FIFO, active low
//   o_alm_full_thresh   active almost-full threshold
//   o_alm_empty_thresh  active almost-empty threshold
// ---------------------------------------------------------------------------
module amiq_fifo_cfg_ctrl #(
  parameter int P              = 4,
  parameter int DEF_ALM_FULL   = 2,
  parameter int DEF_ALM_EMPTY  = 2,
  parameter int RST_CYCLES     = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cfg_valid,
  output logic         o_cfg_ready,
  input  logic [1:0]   i_cfg_op,
  input  logic [P-1:0] i_cfg_data,
  output logic         o_cfg_err,
  output logic         o_busy,
  output logic         o_fifo_rst_n,
  output logic [P-1:0] o_alm_full_thresh,
  output logic [P-1:0] o_alm_empty_thresh
);

  localparam int CNT_MAX = (RST_CYCLES > RECOVER_CYCLES) ? RST_CYCLES : RECOVER_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_CNT = CW'(RST_CYCLES);
  localparam logic [CW-1:0] REC_CNT = CW'(RECOVER_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  // DEPTH = 2**P expressed in P+1 bits so the threshold sum never overflows
  localparam logic [P:0] DEPTH = {1'b1, {P{1'b0}}};

  localparam logic [P-1:0] DEF_FULL  = P'(DEF_ALM_FULL);
  localparam logic [P-1:0] DEF_EMPTY = P'(DEF_ALM_EMPTY);

  localparam logic [1:0] OP_SET_FULL  = 2'b00;
  localparam logic [1:0] OP_SET_EMPTY = 2'b01;
  localparam logic [1:0] OP_FLUSH     = 2'b10;
  localparam logic [1:0] OP_COMMIT    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_countNext;

  logic [P-1:0]    r_shadowFull;
  logic [P-1:0]    r_shadowEmpty;
  logic [P-1:0]    r_activeFull;
  logic [P-1:0]    r_activeEmpty;
  logic            r_cfgErr;

  logic            w_xfer;
  logic [P:0]      w_shadowSum;
  logic            w_commitOk;

  // Requests are only taken in IDLE; anything presented elsewhere is dropped.
  assign w_xfer = i_cfg_valid && (r_state == ST_IDLE);

  assign w_shadowSum = {1'b0, r_shadowFull} + {1'b0, r_shadowEmpty};
  assign w_commitOk  = (r_shadowFull != '0) && (r_shadowEmpty != '0) && (w_shadowSum <= DEPTH);

  // Handshake and FIFO reset outputs are pure decodes of the state register.
  assign o_cfg_ready        = (r_state == ST_IDLE);
  assign o_busy             = (r_state != ST_IDLE);
  assign o_fifo_rst_n       = (r_state != ST_FLUSH);
  assign o_cfg_err          = r_cfgErr;
  assign o_alm_full_thresh  = r_activeFull;
  assign o_alm_empty_thresh = r_activeEmpty;

  // State and phase counter. Reset parks the block in FLUSH with a full
  // count so the FIFO sees the same reset pulse as an explicit flush.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_FLUSH;
      r_count <= RST_CNT;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  // Next-state logic. The counter holds the number of cycles left in the
  // current phase, so the phase ends on the edge where it reads one.
  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && (i_cfg_op == OP_FLUSH)) begin
          w_stateNext = ST_FLUSH;
          w_countNext = RST_CNT;
        end
      end
      ST_FLUSH: begin
        if (r_count <= CNT_ONE) begin
          if (RECOVER_CYCLES == 0) begin
            w_stateNext = ST_IDLE;
            w_countNext = CNT_ZERO;
          end else begin
            w_stateNext = ST_RECOVER;
            w_countNext = REC_CNT;
          end
        end else begin
          w_countNext = r_count - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (r_count <= CNT_ONE) begin
          w_stateNext = ST_IDLE;
          w_countNext = CNT_ZERO;
        end else begin
          w_countNext = r_count - CNT_ONE;
        end
      end
      default: begin
        w_stateNext = ST_FLUSH;
        w_countNext = RST_CNT;
      end
    endcase
  end

  // Shadow / active thresholds and the commit error pulse. A rejected
  // commit leaves every threshold register untouched; a FLUSH op keeps them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadowFull  <= DEF_FULL;
      r_shadowEmpty <= DEF_EMPTY;
      r_activeFull  <= DEF_FULL;
      r_activeEmpty <= DEF_EMPTY;
      r_cfgErr      <= 1'b0;
    end else begin
      r_cfgErr <= 1'b0;
      if (w_xfer) begin
        case (i_cfg_op)
          OP_SET_FULL:  r_shadowFull  <= i_cfg_data;
          OP_SET_EMPTY: r_shadowEmpty <= i_cfg_data;
          OP_COMMIT: begin
            if (w_commitOk) begin
              r_activeFull  <= r_shadowFull;
              r_activeEmpty <= r_shadowEmpty;
            end else begin
              r_cfgErr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amiq_fifo_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_amiq_fifo_cfg_ctrl
//   Drives directed and random config traffic into amiq_fifo_cfg_ctrl. A
//   reference model, kept as edge counts and plain threshold variables,
//   pushes the expected outputs for each cycle into a queue; a monitor on
//   the falling edge pops and compares against the DUT.
// ---------------------------------------------------------------------------
module tb_amiq_fifo_cfg_ctrl;

  localparam int P         = 4;
  localparam int DEF_FULL  = 2;
  localparam int DEF_EMPTY = 2;
  localparam int RSTC      = 4;
  localparam int RECC      = 2;
  localparam int DEPTH     = 16;

  localparam logic [1:0] OP_SET_FULL  = 2'b00;
  localparam logic [1:0] OP_SET_EMPTY = 2'b01;
  localparam logic [1:0] OP_FLUSH     = 2'b10;
  localparam logic [1:0] OP_COMMIT    = 2'b11;

  logic         clk = 1'b0;
  logic         rstN;
  logic         cfgValid;
  logic         cfgReady;
  logic [1:0]   cfgOp;
  logic [P-1:0] cfgData;
  logic         cfgErr;
  logic         busy;
  logic         fifoRstN;
  logic [P-1:0] almFull;
  logic [P-1:0] almEmpty;

  typedef struct {
    logic         ready;
    logic         fifoRstN;
    logic         err;
    logic [P-1:0] full;
    logic [P-1:0] empty;
  } expect_t;

  expect_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  // Reference model: edges completed so far, edge count when the last
  // reset/flush phase started, and plain threshold variables.
  int           edgeNo   = 0;
  int           baseEdge = 0;
  logic [P-1:0] mShadowFull;
  logic [P-1:0] mShadowEmpty;
  logic [P-1:0] mFull;
  logic [P-1:0] mEmpty;
  logic         mErr;

  amiq_fifo_cfg_ctrl #(
    .P(P), .DEF_ALM_FULL(DEF_FULL), .DEF_ALM_EMPTY(DEF_EMPTY),
    .RST_CYCLES(RSTC), .RECOVER_CYCLES(RECC)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rstN),
    .i_cfg_valid        (cfgValid),
    .o_cfg_ready        (cfgReady),
    .i_cfg_op           (cfgOp),
    .i_cfg_data         (cfgData),
    .o_cfg_err          (cfgErr),
    .o_busy             (busy),
    .o_fifo_rst_n       (fifoRstN),
    .o_alm_full_thresh  (almFull),
    .o_alm_empty_thresh (almEmpty)
  );

  always #5 clk = ~clk;

  function automatic bit modelReady();
    return rstN && ((edgeNo - baseEdge) >= (RSTC + RECC));
  endfunction

  function automatic bit commitAllowed(input logic [P-1:0] f, input logic [P-1:0] e);
    return (f != 0) && (e != 0) && ((int'(f) + int'(e)) <= DEPTH);
  endfunction

  task automatic resetModel();
    mShadowFull  = P'(DEF_FULL);
    mShadowEmpty = P'(DEF_EMPTY);
    mFull        = P'(DEF_FULL);
    mEmpty       = P'(DEF_EMPTY);
    mErr         = 1'b0;
    baseEdge     = edgeNo;
  endtask

  task automatic pushExpect();
    expect_t e;
    e.ready    = modelReady();
    e.fifoRstN = rstN && ((edgeNo - baseEdge) >= RSTC);
    e.err      = mErr;
    e.full     = mFull;
    e.empty    = mEmpty;
    expQ.push_back(e);
  endtask

  // One clock: retire the edge into the model using the inputs that were
  // live at it, apply the new reset level, queue the expected outputs for
  // this cycle, then drive the inputs for the next edge.
  task automatic applyStimulus(input logic v, input logic [1:0] op,
                               input logic [P-1:0] d, input logic r);
    bit readyBefore;
    readyBefore = modelReady();
    @(posedge clk);
    edgeNo++;
    #1;
    mErr = 1'b0;
    if (!rstN) begin
      baseEdge = edgeNo;
    end else if (readyBefore && cfgValid) begin
      case (cfgOp)
        OP_SET_FULL:  mShadowFull  = cfgData;
        OP_SET_EMPTY: mShadowEmpty = cfgData;
        OP_FLUSH:     baseEdge     = edgeNo;
        default: begin
          if (commitAllowed(mShadowFull, mShadowEmpty)) begin
            mFull  = mShadowFull;
            mEmpty = mShadowEmpty;
          end else begin
            mErr = 1'b1;
          end
        end
      endcase
    end
    if (!r) begin
      rstN = 1'b0;
      resetModel();
    end else begin
      rstN = 1'b1;
    end
    pushExpect();
    cfgValid = v;
    cfgOp    = op;
    cfgData  = d;
  endtask

  task automatic waitReady();
    int n;
    n = 0;
    while (!modelReady() && n < 40) begin
      applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
      n++;
    end
    compared++;
    if (!modelReady()) begin
      mismatched++;
      $display("[TB] FAIL ready_timeout: waited %0d cycles, required ready within 40", n);
    end
  endtask

  task automatic checkOne(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, edgeNo, act, exp);
    end
  endtask

  task automatic checkOutput(input expect_t e);
    checkOne("cfg_ready",  8'(cfgReady), 8'(e.ready));
    checkOne("busy",       8'(busy),     8'(!e.ready));
    checkOne("fifo_rst_n", 8'(fifoRstN), 8'(e.fifoRstN));
    checkOne("cfg_err",    8'(cfgErr),   8'(e.err));
    checkOne("alm_full",   8'(almFull),  8'(e.full));
    checkOne("alm_empty",  8'(almEmpty), 8'(e.empty));
  endtask

  // Monitor: one expected snapshot per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) begin
      expect_t e;
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  initial begin
    logic [1:0]   op;
    logic [P-1:0] d;
    int           r;

    rstN     = 1'b0;
    cfgValid = 1'b0;
    cfgOp    = OP_SET_FULL;
    cfgData  = '0;
    resetModel();

    // Power-up sequence
    repeat (3) applyStimulus(1'b0, OP_SET_FULL, '0, 1'b0);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
    waitReady();

    // Back-to-back set/commit, then two rejected commits
    applyStimulus(1'b1, OP_SET_FULL,  4'd5,  1'b1);
    applyStimulus(1'b1, OP_SET_EMPTY, 4'd3,  1'b1);
    applyStimulus(1'b1, OP_COMMIT,    4'd0,  1'b1);
    applyStimulus(1'b1, OP_SET_EMPTY, 4'd0,  1'b1);
    applyStimulus(1'b1, OP_COMMIT,    4'd0,  1'b1);
    applyStimulus(1'b1, OP_SET_FULL,  4'd10, 1'b1);
    applyStimulus(1'b1, OP_SET_EMPTY, 4'd7,  1'b1);
    applyStimulus(1'b1, OP_COMMIT,    4'd0,  1'b1);
    repeat (2) applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);

    // Flush with valid held high through the whole busy window
    repeat (7) applyStimulus(1'b1, OP_FLUSH, '0, 1'b1);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
    waitReady();

    // Reset while the flush counter reads two
    applyStimulus(1'b1, OP_FLUSH, '0, 1'b1);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b0);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b0);
    applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);
    waitReady();

    // Sum exactly equal to DEPTH is accepted
    applyStimulus(1'b1, OP_SET_FULL,  4'd15, 1'b1);
    applyStimulus(1'b1, OP_SET_EMPTY, 4'd1,  1'b1);
    applyStimulus(1'b1, OP_COMMIT,    4'd0,  1'b1);
    repeat (2) applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);

    // Random traffic including occasional flushes and resets
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)       op = OP_SET_FULL;
      else if (r < 6)  op = OP_SET_EMPTY;
      else if (r == 6) op = OP_FLUSH;
      else             op = OP_COMMIT;
      d = P'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 3) != 0), op, d, ($urandom_range(0, 99) != 0));
    end
    repeat (3) applyStimulus(1'b0, OP_SET_FULL, '0, 1'b1);

    @(negedge clk);
    @(negedge clk);
    #1;
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL queue_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
